spi_regbank: RTL
================

SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 Parameter DATA_W, default 8: register width and data-field width in bits, range 1..32.
REQ-002 Parameter ADDR_W, default 7: address-field width in bits, range 1..15.
REQ-003 Parameter NUM_REGS, default 5: number of implemented registers, range 1..2**ADDR_W.
REQ-004 Parameter SYNC_STAGES, default 2: flip-flop depth of each input synchroniser, range 2..4.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 nCS  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 SCLK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-009 COPI  input  1  controller-out serial data, MSB first.
REQ-010 CIPO  output  1  peripheral-out serial data, MSB first.
REQ-011 cipo_oe  output  1  high while CIPO is actively driven.
REQ-012 reg_q  output  NUM_REGS*DATA_W  flattened register contents; register k occupies bits [k*DATA_W +: DATA_W].
REQ-013 wr_strobe  output  NUM_REGS  one-clk pulse on bit k when register k is written.

Function
REQ-014 nCS, SCLK and COPI SHALL each pass through a SYNC_STAGES-deep synchroniser; all decoding SHALL use only synchronised signals.
REQ-015 Frame format SHALL be F = 1+ADDR_W+DATA_W bits: bit 0 R/W (1 = write, 0 = read), then address MSB-first, then data MSB-first.
REQ-016 A synchronised nCS falling edge SHALL clear the bit counter and the receive shift register and start a new frame.
REQ-017 COPI SHALL be sampled on each synchronised SCLK rising edge while synchronised nCS is low.
REQ-018 Bits beyond F within one nCS-low window SHALL be ignored; the bit counter SHALL saturate at F.
REQ-019 Write: if the rising edge carrying bit F-1 is detected in cycle N, register addr and wr_strobe[addr] SHALL both update in cycle N+1; the strobe SHALL last exactly one cycle.
REQ-020 Writes with addr >= NUM_REGS SHALL be discarded without a strobe.
REQ-021 A synchronised nCS rising edge before bit F-1 SHALL abort the frame; no register SHALL change and no strobe SHALL fire.
REQ-022 Read: on the rising edge carrying the last address bit, the transmit register SHALL load register addr, or all zeros if addr >= NUM_REGS.
REQ-023 The transmit MSB SHALL appear on CIPO within 1 clk of that load; each later synchronised SCLK falling edge SHALL shift out the next bit, for DATA_W bits in total.
REQ-024 cipo_oe SHALL be high from the transmit load until synchronised nCS rises; outside that window CIPO SHALL be 0.
REQ-025 Correct operation SHALL require an SCLK high and low time of at least SYNC_STAGES+3 clk periods; behaviour at faster SCLK is unspecified.
REQ-026 A write landing in the same cycle as a read load of the same register SHALL NOT occur (frames are serial); reg_q SHALL hold its value between writes.

Reset
REQ-027 On rst_n low: reg_q = 0, wr_strobe = 0, CIPO = 0, cipo_oe = 0, bit counter = 0, synchronisers = idle (nCS = 1, SCLK = 0, COPI = 0).
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release, the first frame SHALL start only on a new nCS falling edge.

Configuration
REQ-029 Macro SPI_REGBANK_READBACK_EN defined: the read path of REQ-022..REQ-024 SHALL be implemented.
REQ-030 Macro SPI_REGBANK_READBACK_EN undefined: CIPO and cipo_oe SHALL be tied to 0, and read frames SHALL be accepted and discarded with no side effects.

Verification
REQ-031 Defaults; write frame 1,0x04,0xA5 -> reg_q[39:32] = 0xA5 and wr_strobe = 5'b10000 for exactly one cycle; other registers stay 0.
REQ-032 Defaults; write to addr 0x10 with data 0xFF -> reg_q unchanged, wr_strobe never asserted.
REQ-033 Defaults; raise nCS after 12 bits of a write to addr 1 -> no change; a following full write 1,0x01,0x3C -> reg_q[15:8] = 0x3C.
REQ-034 READBACK_EN defined; write addr 2 = 0x5A, then read addr 2 -> CIPO shifts 0,1,0,1,1,0,1,0 and cipo_oe is high until nCS rises; read addr 0x7F -> eight 0s.
REQ-035 DATA_W=16, ADDR_W=3, NUM_REGS=8, SYNC_STAGES=3; write addr 7 = 0xBEEF, then assert rst_n low mid-frame -> reg_q = 0; a new write after release succeeds.
REQ-036 Defaults; send 24 bits in one nCS window (a valid write to addr 0 = 0x11, then 8 extra bits of 0xFF) -> reg_q[7:0] = 0x11 and exactly one strobe.

Source files
------------

// File: rtl/spi_regbank.sv
// SPI mode-0 peripheral giving serial access to a bank of NUM_REGS registers of DATA_W bits.
// Define SPI_REGBANK_READBACK_EN to build the CIPO read path; otherwise CIPO and cipo_oe stay low.
module spi_regbank #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0]  ADDR_END  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  FRAME_END = CNT_W'(FRAME_W);
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, copi_sync;
    logic [SYNC_STAGES:0]   warm;
    logic                   ncs_s, sclk_s, copi_s;
    logic                   ncs_d, sclk_d;
    logic                   cs_fall, cs_rise, sck_rise;
    logic                   in_frame;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_W-2:0]     rx_sr;
    logic [FRAME_W-1:0]     frame_word;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_fire;

    assign ncs_s  = ncs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign copi_s = copi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync  <= '1;
            sclk_sync <= '0;
            copi_sync <= '0;
            warm      <= '0;
            ncs_d     <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], nCS};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            copi_sync <= {copi_sync[SYNC_STAGES-1-1:0], COPI};
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
            ncs_d     <= ncs_s;
            sclk_d    <= sclk_s;
        end
    end

    // A falling edge only counts once both compared nCS samples are real, so an nCS
    // held low through reset cannot masquerade as a new frame start.
    assign cs_fall  = warm[SYNC_STAGES] & ncs_d & ~ncs_s;
    assign cs_rise  = ~ncs_d & ncs_s;
    assign sck_rise = in_frame & ~ncs_s & ~sclk_d & sclk_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame <= 1'b0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
        end else if (cs_fall) begin
            in_frame <= 1'b1;
            bit_cnt  <= '0;
            rx_sr    <= '0;
        end else if (cs_rise) begin
            in_frame <= 1'b0;
        end else if (sck_rise && bit_cnt != FRAME_END) begin
            rx_sr   <= {rx_sr[FRAME_W-3:0], copi_s};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign frame_word = {rx_sr, copi_s};
    assign wr_addr    = frame_word[FRAME_W-2 -: ADDR_W];
    assign wr_data    = frame_word[DATA_W-1:0];
    assign wr_fire    = sck_rise && (bit_cnt == LAST_BIT) && frame_word[FRAME_W-1]
                        && ({1'b0, wr_addr} < REG_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q     <= '0;
            wr_strobe <= '0;
        end else begin
            wr_strobe <= '0;
            if (wr_fire) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (wr_addr == ADDR_W'(k)) begin
                        reg_q[k*DATA_W +: DATA_W] <= wr_data;
                        wr_strobe[k]              <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SPI_REGBANK_READBACK_EN
    logic              sck_fall, rd_fire;
    logic [ADDR_W:0]   hdr_word;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data, tx_sr;

    assign sck_fall = in_frame & ~ncs_s & sclk_d & ~sclk_s;
    assign hdr_word = {rx_sr[ADDR_W-1:0], copi_s};
    assign rd_addr  = hdr_word[ADDR_W-1:0];
    assign rd_fire  = sck_rise && (bit_cnt == ADDR_END) && !hdr_word[ADDR_W];

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) rd_data = reg_q[k*DATA_W +: DATA_W];
        end
    end

    // MSB goes out with the load; each following SCLK fall presents the next bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr   <= '0;
            CIPO    <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (cs_rise) begin
            tx_sr   <= '0;
            CIPO    <= 1'b0;
            cipo_oe <= 1'b0;
        end else if (rd_fire) begin
            tx_sr   <= rd_data << 1;
            CIPO    <= rd_data[DATA_W-1];
            cipo_oe <= 1'b1;
        end else if (sck_fall && cipo_oe) begin
            tx_sr   <= tx_sr << 1;
            CIPO    <= tx_sr[DATA_W-1];
        end
    end
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule
